// File: rtl/crop_pkg.sv
// -----------------------------------------------------------------------------
// crop_pkg
//   Shared types and helpers for the multi-crop streaming front end.
//   - state_t       : top-level run FSM states
//   - max_y1/max_x1 : largest legal crop origin for a given image/crop size
//   - clamp_row/col : saturate a requested origin to the largest legal one
//   - in_crop       : membership test of a pixel (r,c) in a crop window
//   All helpers work on int so the window end (origin + size) is always
//   formed with headroom above the coordinate width and can never wrap.
// -----------------------------------------------------------------------------
package crop_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int max_y1(input int in_rows, input int out_rows);
    return in_rows - out_rows;
  endfunction

  function automatic int max_x1(input int in_cols, input int out_cols);
    return in_cols - out_cols;
  endfunction

  function automatic int clamp_row(input int y1, input int max_y);
    return (y1 > max_y) ? max_y : y1;
  endfunction

  function automatic int clamp_col(input int x1, input int max_x);
    return (x1 > max_x) ? max_x : x1;
  endfunction

  function automatic logic in_crop(input int r, input int c,
                                   input int y1, input int x1,
                                   input int out_rows, input int out_cols);
    return (r >= y1) && (r < y1 + out_rows) &&
           (c >= x1) && (c < x1 + out_cols);
  endfunction

endpackage

// File: rtl/crop_out_slot.sv
// -----------------------------------------------------------------------------
// crop_out_slot
//   One-entry AXI-stream register slice for a single crop channel.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (empties the slot)
//     i_load     : write i_data into the slot this cycle
//     i_data     : pixel to store
//     i_ready    : downstream TREADY
//     o_valid    : downstream TVALID (slot full)
//     o_data     : downstream TDATA, held stable while o_valid && !i_ready
//   A load in the same cycle as a drain keeps the slot full with the new
//   pixel, which is what gives full throughput with an always-ready sink.
//   The producer only asserts i_load when the slot is empty or draining.
// -----------------------------------------------------------------------------
module crop_out_slot
  import crop_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // NOTE: the data register is deliberately not reset; it is only observed
  // while r_valid is set, and leaving it out of reset keeps it a plain
  // enable flop.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/multi_crop_stream.sv
// -----------------------------------------------------------------------------
// multi_crop_stream
//   Single-pass extraction of NUM_CROPS OUT_ROWSxOUT_COLS crops from one
//   raster-order IN_ROWSxIN_COLS image, one output stream per crop.
//   Ports:
//     ap_clk, ap_rst          : clock, synchronous active-high reset
//     ap_start                : start a run (sampled in IDLE only)
//     ap_done, ap_ready       : one-cycle pulse at end of run
//     ap_idle                 : high while IDLE
//     crop_Y1_T*              : NUM_CROPS row origins, channel order
//     crop_X1_T*              : NUM_CROPS column origins, channel order
//     img_input_T*            : raster pixel stream
//     crop_out_TDATA          : channel c at [c*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]
//     crop_out_TVALID/TREADY  : per-channel handshake
//   Flow: IDLE -> LOAD (collect origins) -> STREAM (broadcast pixels into
//   every crop slot that contains them) -> DONE (pulse) -> IDLE.
// -----------------------------------------------------------------------------
module multi_crop_stream
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int NUM_CROPS        = 4
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst,
  input  logic                                 ap_start,
  output logic                                 ap_done,
  output logic                                 ap_ready,
  output logic                                 ap_idle,
  input  logic [IMG_ROW_BITWIDTH-1:0]          crop_Y1_TDATA,
  input  logic                                 crop_Y1_TVALID,
  output logic                                 crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0]          crop_X1_TDATA,
  input  logic                                 crop_X1_TVALID,
  output logic                                 crop_X1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]           img_input_TDATA,
  input  logic                                 img_input_TVALID,
  output logic                                 img_input_TREADY,
  output logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0] crop_out_TDATA,
  output logic [NUM_CROPS-1:0]                 crop_out_TVALID,
  input  logic [NUM_CROPS-1:0]                 crop_out_TREADY
);

  localparam int MAX_Y1 = max_y1(IN_ROWS, OUT_ROWS);
  localparam int MAX_X1 = max_x1(IN_COLS, OUT_COLS);
  localparam int CNT_W  = $clog2(NUM_CROPS + 1);

  localparam logic [CNT_W-1:0]            CNT_FULL = CNT_W'(NUM_CROPS);
  localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(NUM_CROPS - 1);
  localparam logic [IMG_ROW_BITWIDTH-1:0] LAST_ROW = IMG_ROW_BITWIDTH'(IN_ROWS - 1);
  localparam logic [IMG_COL_BITWIDTH-1:0] LAST_COL = IMG_COL_BITWIDTH'(IN_COLS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [CNT_W-1:0]            r_y_cnt;
  logic [CNT_W-1:0]            r_x_cnt;
  logic [IMG_ROW_BITWIDTH-1:0] r_y1 [NUM_CROPS];
  logic [IMG_COL_BITWIDTH-1:0] r_x1 [NUM_CROPS];

  logic [IMG_ROW_BITWIDTH-1:0] r_row;
  logic [IMG_COL_BITWIDTH-1:0] r_col;
  // Set once the final raster pixel has been accepted; closes the input.
  logic                        r_eos;

  logic                        w_start;
  logic                        w_y_acc;
  logic                        w_x_acc;
  logic                        w_y_full_nxt;
  logic                        w_x_full_nxt;
  logic                        w_accept;
  logic [NUM_CROPS-1:0]        w_hit;
  logic [NUM_CROPS-1:0]        w_slot_ok;
  logic [NUM_CROPS-1:0]        w_slot_valid;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign w_start = (r_state == IDLE) && ap_start;

  assign crop_Y1_TREADY = (r_state == LOAD) && (r_y_cnt != CNT_FULL);
  assign crop_X1_TREADY = (r_state == LOAD) && (r_x_cnt != CNT_FULL);
  assign w_y_acc        = crop_Y1_TREADY && crop_Y1_TVALID;
  assign w_x_acc        = crop_X1_TREADY && crop_X1_TVALID;

  // "Full after this edge": lets LOAD leave on the very cycle the last
  // origin of the slower stream is captured.
  assign w_y_full_nxt = (r_y_cnt == CNT_FULL) || (w_y_acc && (r_y_cnt == CNT_LAST));
  assign w_x_full_nxt = (r_x_cnt == CNT_FULL) || (w_x_acc && (r_x_cnt == CNT_LAST));

  // A pixel may enter only if every crop that wants it has room. Crops that
  // do not contain it impose nothing, so pixels outside all crops flow at
  // one per cycle. TVALID is intentionally absent from this expression.
  assign img_input_TREADY = (r_state == STREAM) && !r_eos && (&w_slot_ok);
  assign w_accept         = img_input_TREADY && img_input_TVALID;

  assign crop_out_TVALID = w_slot_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    ap_idle     = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_y_full_nxt && w_x_full_nxt) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (r_eos && (w_slot_valid == '0)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        ap_done     = 1'b1;
        ap_ready    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Origin capture (Y and X streams are independent)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_y_cnt <= '0;
      r_x_cnt <= '0;
      for (int k = 0; k < NUM_CROPS; k++) begin
        r_y1[k] <= '0;
        r_x1[k] <= '0;
      end
    end else if (w_start) begin
      r_y_cnt <= '0;
      r_x_cnt <= '0;
    end else begin
      if (w_y_acc) begin
        r_y_cnt <= r_y_cnt + CNT_W'(1);
      end
      if (w_x_acc) begin
        r_x_cnt <= r_x_cnt + CNT_W'(1);
      end
      for (int k = 0; k < NUM_CROPS; k++) begin
        if (w_y_acc && (r_y_cnt == CNT_W'(k))) begin
          r_y1[k] <= IMG_ROW_BITWIDTH'(clamp_row(int'(crop_Y1_TDATA), MAX_Y1));
        end
        if (w_x_acc && (r_x_cnt == CNT_W'(k))) begin
          r_x1[k] <= IMG_COL_BITWIDTH'(clamp_col(int'(crop_X1_TDATA), MAX_X1));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raster position of the next pixel to be accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_row <= '0;
      r_col <= '0;
      r_eos <= 1'b0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
      r_eos <= 1'b0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        if (r_row == LAST_ROW) begin
          r_eos <= 1'b1;
        end else begin
          r_row <= r_row + IMG_ROW_BITWIDTH'(1);
        end
      end else begin
        r_col <= r_col + IMG_COL_BITWIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-crop membership, back-pressure and output slots
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CROPS; k++) begin : g_crop
    assign w_hit[k] = in_crop(int'(r_row), int'(r_col),
                              int'(r_y1[k]), int'(r_x1[k]),
                              OUT_ROWS, OUT_COLS);

    assign w_slot_ok[k] = !w_hit[k] || !w_slot_valid[k] || crop_out_TREADY[k];

    crop_out_slot #(
      .W (PIXEL_BIT_WIDTH)
    ) u_slot (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .i_load  (w_accept && w_hit[k]),
      .i_data  (img_input_TDATA),
      .i_ready (crop_out_TREADY[k]),
      .o_valid (w_slot_valid[k]),
      .o_data  (crop_out_TDATA[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH])
    );
  end

endmodule
